// File: rtl/wb_regfile.sv
// Write-back stage and integer register file.
// Selects the write-back value, commits it to x1..x(NREGS-1) and serves two decode read
// ports that see a same-cycle commit through write-through bypass. x0 is not stored.
module wb_regfile #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   MEM_WB_rd,
   input  logic [XLEN-1:0] MEM_WB_ALU,
   input  logic [XLEN-1:0] MEM_WB_Read_Data,
   input  logic            MEM_WB_RegWrite,
   input  logic            MEM_WB_MemtoReg,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] ReadData1,
   output logic [XLEN-1:0] ReadData2,
   output logic [XLEN-1:0] WB_Data,
   output logic            WB_Valid,
   output logic [31:0]     retire_cnt
);

   logic [XLEN-1:0] regs_q [NREGS-1:1];
   logic [XLEN-1:0] regs_d [NREGS-1:1];
   logic [31:0]     retire_cnt_q;
   logic [31:0]     retire_cnt_d;

   // Write-back mux and commit qualifier; reset suppresses commits and bypass alike.
   always_comb begin
      WB_Data  = MEM_WB_MemtoReg ? MEM_WB_Read_Data : MEM_WB_ALU;
      WB_Valid = MEM_WB_RegWrite && (MEM_WB_rd != '0) && !reset;
   end

   // Next-state for the register array and retire counter; reset wins over a commit.
   always_comb begin
      regs_d       = regs_q;
      retire_cnt_d = retire_cnt_q;
      if (reset) begin
         for (int unsigned i = 1; i < NREGS; i++) begin
            regs_d[i] = '0;
         end
         retire_cnt_d = '0;
      end else if (WB_Valid) begin
         regs_d[MEM_WB_rd] = WB_Data;
         retire_cnt_d      = retire_cnt_q + 32'd1;
      end
   end

   // State update.
   always_ff @(posedge clk) begin
      regs_q       <= regs_d;
      retire_cnt_q <= retire_cnt_d;
   end

   // Read ports: x0 reads zero, a same-cycle commit to the same index is bypassed.
   always_comb begin
      if (rs1 == '0) begin
         ReadData1 = '0;
      end else if (WB_Valid && (rs1 == MEM_WB_rd)) begin
         ReadData1 = WB_Data;
      end else begin
         ReadData1 = regs_q[rs1];
      end

      if (rs2 == '0) begin
         ReadData2 = '0;
      end else if (WB_Valid && (rs2 == MEM_WB_rd)) begin
         ReadData2 = WB_Data;
      end else begin
         ReadData2 = regs_q[rs2];
      end
   end

   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, ALU/load commit paths, bypass, x0 writes,
// reset-vs-commit priority, retire counter wrap and idle writes with unknown data.
module tb_wb_regfile;

   localparam int unsigned XLEN = 64;
   localparam int unsigned AW   = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   MEM_WB_rd;
   logic [XLEN-1:0] MEM_WB_ALU;
   logic [XLEN-1:0] MEM_WB_Read_Data;
   logic            MEM_WB_RegWrite;
   logic            MEM_WB_MemtoReg;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] ReadData1;
   logic [XLEN-1:0] ReadData2;
   logic [XLEN-1:0] WB_Data;
   logic            WB_Valid;
   logic [31:0]     retire_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_regfile #(.XLEN(64), .NREGS(32), .AW(5)) dut (
      .clk             (clk),
      .reset           (reset),
      .MEM_WB_rd       (MEM_WB_rd),
      .MEM_WB_ALU      (MEM_WB_ALU),
      .MEM_WB_Read_Data(MEM_WB_Read_Data),
      .MEM_WB_RegWrite (MEM_WB_RegWrite),
      .MEM_WB_MemtoReg (MEM_WB_MemtoReg),
      .rs1             (rs1),
      .rs2             (rs2),
      .ReadData1       (ReadData1),
      .ReadData2       (ReadData2),
      .WB_Data         (WB_Data),
      .WB_Valid        (WB_Valid),
      .retire_cnt      (retire_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      MEM_WB_RegWrite  = 1'b0;
      MEM_WB_MemtoReg  = 1'b0;
      MEM_WB_rd        = '0;
      MEM_WB_ALU       = '0;
      MEM_WB_Read_Data = '0;
   endtask

   initial begin
      reset = 1'b1;
      rs1   = '0;
      rs2   = '0;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("init_retire", 64'(retire_cnt), 64'd0);
      rs1 = 5'd5;
      #1;
      check("init_x5", ReadData1, 64'd0);

      // 1: preload x5, then reset one cycle.
      MEM_WB_rd = 5'd5; MEM_WB_ALU = 64'hAA; MEM_WB_RegWrite = 1'b1;
      tick();
      idle();
      #1;
      check("preload_x5", ReadData1, 64'hAA);
      check("preload_retire", 64'(retire_cnt), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("reset_x5", ReadData1, 64'd0);
      check("reset_retire", 64'(retire_cnt), 64'd0);

      // 2: ALU path commit.
      MEM_WB_rd = 5'd3; MEM_WB_ALU = 64'h1234; MEM_WB_Read_Data = 64'h9999;
      MEM_WB_MemtoReg = 1'b0; MEM_WB_RegWrite = 1'b1;
      #1;
      check("alu_wbdata", WB_Data, 64'h1234);
      check("alu_wbvalid", 64'(WB_Valid), 64'd1);
      tick();
      idle();
      rs1 = 5'd3;
      #1;
      check("alu_x3", ReadData1, 64'h1234);
      check("alu_retire", 64'(retire_cnt), 64'd1);

      // 3: load path with dual bypass on the same index.
      MEM_WB_rd = 5'd7; MEM_WB_Read_Data = 64'hDEADBEEF; MEM_WB_ALU = 64'h1111;
      MEM_WB_MemtoReg = 1'b1; MEM_WB_RegWrite = 1'b1;
      rs1 = 5'd7; rs2 = 5'd7;
      #1;
      check("load_wbdata", WB_Data, 64'hDEADBEEF);
      check("load_byp_rd1", ReadData1, 64'hDEADBEEF);
      check("load_byp_rd2", ReadData2, 64'hDEADBEEF);
      tick();
      idle();
      #1;
      check("load_x7_rd1", ReadData1, 64'hDEADBEEF);
      check("load_x7_rd2", ReadData2, 64'hDEADBEEF);
      check("load_retire", 64'(retire_cnt), 64'd2);
      rs2 = 5'd3;
      #1;
      check("load_x3_kept", ReadData2, 64'h1234);

      // 4: write to x0 is discarded.
      MEM_WB_rd = 5'd0; MEM_WB_ALU = 64'hFFFF; MEM_WB_RegWrite = 1'b1;
      rs1 = 5'd0; rs2 = 5'd0;
      #1;
      check("x0_wbvalid", 64'(WB_Valid), 64'd0);
      check("x0_rd1", ReadData1, 64'd0);
      check("x0_rd2", ReadData2, 64'd0);
      tick();
      idle();
      #1;
      check("x0_rd1_after", ReadData1, 64'd0);
      check("x0_retire", 64'(retire_cnt), 64'd2);

      // 5: reset coincident with a commit; commit is dropped, then lands after deassertion.
      reset = 1'b1;
      MEM_WB_rd = 5'd9; MEM_WB_ALU = 64'h55; MEM_WB_RegWrite = 1'b1;
      rs1 = 5'd9; rs2 = 5'd7;
      #1;
      check("rst_wbvalid", 64'(WB_Valid), 64'd0);
      check("rst_no_bypass", ReadData1, 64'd0);
      tick();
      check("rst_x9", ReadData1, 64'd0);
      check("rst_x7", ReadData2, 64'd0);
      check("rst_retire", 64'(retire_cnt), 64'd0);
      reset = 1'b0;
      #1;
      check("post_rst_wbvalid", 64'(WB_Valid), 64'd1);
      check("post_rst_bypass", ReadData1, 64'h55);
      tick();
      idle();
      #1;
      check("post_rst_x9", ReadData1, 64'h55);
      check("post_rst_retire", 64'(retire_cnt), 64'd1);

      // 6: retire counter wrap.
      dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      check("wrap_preset", 64'(retire_cnt), 64'hFFFF_FFFF);
      MEM_WB_rd = 5'd4; MEM_WB_ALU = 64'h77; MEM_WB_RegWrite = 1'b1;
      tick();
      idle();
      rs1 = 5'd4; rs2 = 5'd9;
      #1;
      check("wrap_retire", 64'(retire_cnt), 64'd0);
      check("wrap_x4", ReadData1, 64'h77);

      // Idle with unknown index/data must leave state untouched.
      MEM_WB_RegWrite  = 1'b0;
      MEM_WB_MemtoReg  = 1'bx;
      MEM_WB_rd        = 'x;
      MEM_WB_ALU       = 'x;
      MEM_WB_Read_Data = 'x;
      tick();
      tick();
      #1;
      check("xidle_wbvalid", 64'(WB_Valid), 64'd0);
      check("xidle_x4", ReadData1, 64'h77);
      check("xidle_x9", ReadData2, 64'h55);
      check("xidle_retire", 64'(retire_cnt), 64'd0);
      idle();
      rs1 = 5'd3; rs2 = 5'd5;
      #1;
      check("xidle_x3", ReadData1, 64'd0);
      check("xidle_x5", ReadData2, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
